// File: rtl/tensor_mac_sequencer.sv
// Job sequencer for the TensorFlowE MAC core: clear, load operand bytes, accumulate, read, capture result.
// Optional CYCLE_COUNT_EN adds job_cycles, the CLEAR-entry to RESULT-entry cycle count of the last good job.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; error is sticky here
// S_CLEAR  | one-cycle accumulator clear (also the abort landing state)
// S_LOAD   | host bytes streamed into the core write port
// S_ACCUM  | enable_accu held for ACC_CYCLES cycles
// S_READ   | one-cycle read strobe
// S_WAIT   | waiting for core_out_valid, bounded by RD_TIMEOUT
// S_RESULT | result held valid until the host consumes it
module tensor_mac_sequencer #(
    parameter int N_PAIRS    = 4,
    parameter int ACC_CYCLES = 4,
    parameter int RD_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] core_data,
    output logic       core_wr_en,
    output logic       core_rd_en,
    output logic       core_clear,
    output logic       core_accu_en,
    input  logic [7:0] core_out_data,
    input  logic       core_out_valid,
    output logic [7:0] result,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       busy,
    output logic       error
`ifdef CYCLE_COUNT_EN
    ,
    output logic [15:0] job_cycles
`endif
);

    localparam int N_BYTES = 2 * N_PAIRS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_ACCUM,
        S_READ,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] byte_cnt, byte_cnt_nxt;
    logic [7:0] acc_cnt, acc_cnt_nxt;
    logic [7:0] to_cnt, to_cnt_nxt;
    logic       aborting, aborting_nxt;
    logic       error_nxt;
    logic [7:0] result_nxt;
    logic       result_valid_nxt;
    logic       wr_nxt;
    logic [7:0] core_data_nxt;
    logic       handshake;

    assign handshake = in_valid && in_ready;

    always_comb begin
        state_nxt        = state;
        byte_cnt_nxt     = byte_cnt;
        acc_cnt_nxt      = acc_cnt;
        to_cnt_nxt       = to_cnt;
        aborting_nxt     = aborting;
        error_nxt        = error;
        result_nxt       = result;
        result_valid_nxt = result_valid;
        wr_nxt           = 1'b0;
        core_data_nxt    = core_data;

        // abort outranks every other transition, including the last load handshake
        if (state != S_IDLE && abort) begin
            state_nxt        = S_CLEAR;
            aborting_nxt     = 1'b1;
            result_valid_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt    = S_CLEAR;
                        error_nxt    = 1'b0;
                        aborting_nxt = 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (aborting) begin
                        state_nxt    = S_IDLE;
                        aborting_nxt = 1'b0;
                    end else begin
                        state_nxt    = S_LOAD;
                        byte_cnt_nxt = '0;
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        wr_nxt        = 1'b1;
                        core_data_nxt = in_data;
                        byte_cnt_nxt  = byte_cnt + 8'd1;
                        if (byte_cnt == 8'(N_BYTES - 1)) begin
                            state_nxt   = S_ACCUM;
                            acc_cnt_nxt = 8'(ACC_CYCLES - 1);
                        end
                    end
                end
                S_ACCUM: begin
                    if (acc_cnt == 8'd0) begin
                        state_nxt = S_READ;
                    end else begin
                        acc_cnt_nxt = acc_cnt - 8'd1;
                    end
                end
                S_READ: begin
                    state_nxt  = S_WAIT;
                    to_cnt_nxt = '0;
                end
                S_WAIT: begin
                    if (core_out_valid) begin
                        state_nxt        = S_RESULT;
                        result_nxt       = core_out_data;
                        result_valid_nxt = 1'b1;
                    end else if (to_cnt == 8'(RD_TIMEOUT - 1)) begin
                        state_nxt = S_IDLE;
                        error_nxt = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt + 8'd1;
                    end
                end
                S_RESULT: begin
                    if (result_ready) begin
                        state_nxt        = S_IDLE;
                        result_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // strobes are flopped from the next state so the core sees clean, glitch-free levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            acc_cnt      <= '0;
            to_cnt       <= '0;
            aborting     <= 1'b0;
            in_ready     <= 1'b0;
            core_data    <= '0;
            core_wr_en   <= 1'b0;
            core_rd_en   <= 1'b0;
            core_clear   <= 1'b0;
            core_accu_en <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            byte_cnt     <= byte_cnt_nxt;
            acc_cnt      <= acc_cnt_nxt;
            to_cnt       <= to_cnt_nxt;
            aborting     <= aborting_nxt;
            in_ready     <= (state_nxt == S_LOAD);
            core_data    <= core_data_nxt;
            core_wr_en   <= wr_nxt;
            core_rd_en   <= (state_nxt == S_READ);
            core_clear   <= (state_nxt == S_CLEAR);
            core_accu_en <= (state_nxt == S_ACCUM);
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            busy         <= (state_nxt != S_IDLE);
            error        <= error_nxt;
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [15:0] cyc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt    <= '0;
            job_cycles <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                cyc_cnt <= '0;
            end else if (cyc_cnt != 16'hFFFF) begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
            // the RESULT entry edge itself is the last counted cycle
            if (state == S_WAIT && state_nxt == S_RESULT) begin
                job_cycles <= (cyc_cnt == 16'hFFFF) ? 16'hFFFF : cyc_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tensor_mac_sequencer.sv
// Randomized self-checking bench for tensor_mac_sequencer against a job-level reference model.
// Build with CYCLE_COUNT_EN defined to also check job_cycles.
module tb_tensor_mac_sequencer;

    localparam int N_PAIRS    = 4;
    localparam int ACC_CYCLES = 4;
    localparam int RD_TIMEOUT = 15;
    localparam int N_BYTES    = 2 * N_PAIRS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] core_data;
    logic       core_wr_en, core_rd_en, core_clear, core_accu_en;
    logic [7:0] core_out_data = '0;
    logic       core_out_valid = 1'b0;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready = 1'b0;
    logic       busy, error;
`ifdef CYCLE_COUNT_EN
    logic [15:0] job_cycles;
`endif

    tensor_mac_sequencer #(
        .N_PAIRS(N_PAIRS), .ACC_CYCLES(ACC_CYCLES), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
`ifdef CYCLE_COUNT_EN
        .job_cycles(job_cycles),
`endif
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_data(core_data), .core_wr_en(core_wr_en), .core_rd_en(core_rd_en),
        .core_clear(core_clear), .core_accu_en(core_accu_en),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // strobe monitor: cumulative totals, only ever written here
    int         clr_tot = 0, rd_tot = 0, accu_tot = 0, wr_tot = 0, excl_tot = 0;
    int         accu_run = 0, accu_last = 0;
    logic [7:0] wr_log [0:4095];

    always @(negedge clk) begin : mon
        int n;
        n = int'(core_clear) + int'(core_rd_en) + int'(core_accu_en) + int'(core_wr_en);
        if (n > 1 && !(n == 2 && core_wr_en && core_accu_en)) excl_tot++;
        if (core_clear) clr_tot++;
        if (core_rd_en) rd_tot++;
        if (core_wr_en) begin
            wr_log[wr_tot & 4095] = core_data;
            wr_tot++;
        end
        if (core_accu_en) begin
            accu_tot++;
            accu_run++;
        end else if (accu_run != 0) begin
            accu_last = accu_run;
            accu_run  = 0;
        end
    end

    logic [7:0] job_bytes [N_BYTES];
    int s_clr, s_rd, s_accu, s_wr, s_excl;

    task automatic begin_job();
        @(negedge clk);
        #1;
        s_clr = clr_tot; s_rd = rd_tot; s_accu = accu_tot; s_wr = wr_tot; s_excl = excl_tot;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_val("start_busy", 32'(busy), 1);
        chk_val("start_err_clr", 32'(error), 0);
        chk_val("start_clear", 32'(core_clear), 1);
    endtask

    task automatic load_phase(input int stall_pct, input int stall_at, input bit noise,
                              output int load_cyc);
        int idx = 0;
        int k = 0;
        int stall_left = 3;
        load_cyc = 0;
        while (idx < N_BYTES && k < 300) begin
            @(negedge clk);
            k++;
            if (noise) start = 1'($urandom_range(0, 1));
            if (idx == stall_at && stall_left > 0) begin
                in_valid = 1'b0;
                stall_left--;
            end else begin
                in_valid = (int'($urandom_range(0, 99)) >= stall_pct);
            end
            in_data = job_bytes[idx];
            if (in_ready) load_cyc++;
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        chk_val("load_done", 32'(idx), N_BYTES);
        chk_val("in_ready_drop", 32'(in_ready), 0);
    endtask

    task automatic wait_rd();
        int k = 0;
        while (!core_rd_en && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk_val("rd_seen", 32'(core_rd_en), 1);
    endtask

    task automatic run_job(input bit directed, input int stall_pct, input int stall_at,
                           input bit timeout, input int rsp_delay, input int rdy_delay,
                           input bit noise);
        logic [7:0] rval, res_before;
        int load_cyc, n;
        for (int i = 0; i < N_BYTES; i++) job_bytes[i] = directed ? 8'(i + 1) : 8'($urandom);
        rval = directed ? 8'h2A : 8'($urandom);
        res_before = result;
        begin_job();
        load_phase(stall_pct, stall_at, noise, load_cyc);
        wait_rd();
        if (timeout) begin
            n = 0;
            while (!error && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk_val("timeout_cycles", 32'(n), RD_TIMEOUT + 1);
            chk_val("timeout_busy", 32'(busy), 0);
            chk_val("timeout_rvalid", 32'(result_valid), 0);
            chk_val("timeout_result", 32'(result), 32'(res_before));
        end else begin
            repeat (rsp_delay + 1) @(negedge clk);
            core_out_valid = 1'b1;
            core_out_data  = rval;
            @(negedge clk);
            core_out_valid = 1'b0;
            core_out_data  = 8'($urandom);
            chk_val("res_valid", 32'(result_valid), 1);
            chk_val("res_data", 32'(result), 32'(rval));
`ifdef CYCLE_COUNT_EN
            chk_val("job_cycles", 32'(job_cycles), 1 + load_cyc + ACC_CYCLES + 1 + rsp_delay + 1);
`endif
            repeat (rdy_delay) @(negedge clk);
            chk_val("res_hold", 32'(result), 32'(rval));
            chk_val("res_hold_valid", 32'(result_valid), 1);
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            chk_val("done_rvalid", 32'(result_valid), 0);
            chk_val("done_busy", 32'(busy), 0);
            chk_val("done_result", 32'(result), 32'(rval));
        end
        #1;
        chk_val("wr_count", 32'(wr_tot - s_wr), N_BYTES);
        for (int i = 0; i < N_BYTES; i++)
            chk_val("wr_byte", 32'(wr_log[(s_wr + i) & 4095]), 32'(job_bytes[i]));
        chk_val("clear_pulses", 32'(clr_tot - s_clr), 1);
        chk_val("accu_cycles", 32'(accu_tot - s_accu), ACC_CYCLES);
        chk_val("accu_contig", 32'(accu_last), ACC_CYCLES);
        chk_val("rd_pulses", 32'(rd_tot - s_rd), 1);
        chk_val("strobe_excl", 32'(excl_tot - s_excl), 0);
    endtask

    task automatic abort_job();
        int load_cyc;
        for (int i = 0; i < N_BYTES; i++) job_bytes[i] = 8'($urandom);
        begin_job();
        load_phase(0, -1, 1'b0, load_cyc);
        chk_val("abort_accu1", 32'(core_accu_en), 1);
        @(negedge clk);
        chk_val("abort_accu2", 32'(core_accu_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_val("abort_accu_off", 32'(core_accu_en), 0);
        chk_val("abort_clear", 32'(core_clear), 1);
        @(negedge clk);
        chk_val("abort_idle", 32'(busy), 0);
        chk_val("abort_clear_end", 32'(core_clear), 0);
        repeat (20) @(negedge clk);
        #1;
        chk_val("abort_no_rd", 32'(rd_tot - s_rd), 0);
        chk_val("abort_clears", 32'(clr_tot - s_clr), 2);
        chk_val("abort_accu_cnt", 32'(accu_tot - s_accu), 2);
    endtask

    task automatic idle_valid_ignored();
        logic [7:0] r0;
        @(negedge clk);
        r0 = result;
        core_out_valid = 1'b1;
        core_out_data  = ~r0;
        @(negedge clk);
        core_out_valid = 1'b0;
        @(negedge clk);
        chk_val("idle_valid_result", 32'(result), 32'(r0));
        chk_val("idle_valid_rvalid", 32'(result_valid), 0);
        chk_val("idle_valid_busy", 32'(busy), 0);
    endtask

    task automatic reset_in_wait();
        int load_cyc;
        for (int i = 0; i < N_BYTES; i++) job_bytes[i] = 8'($urandom);
        begin_job();
        load_phase(0, -1, 1'b0, load_cyc);
        wait_rd();
        @(negedge clk);
        chk_val("pre_rst_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("rst_outputs",
                32'({busy, in_ready, core_wr_en, core_rd_en, core_clear, core_accu_en,
                     result_valid, error, result, core_data}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk_val("rst_no_strobes", 32'((clr_tot - s_clr) + (rd_tot - s_rd)), 2);
        chk_val("rst_idle", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk_val("reset_outputs",
                32'({busy, in_ready, core_wr_en, core_rd_en, core_clear, core_accu_en,
                     result_valid, error, result, core_data}), 0);
`ifdef CYCLE_COUNT_EN
        chk_val("reset_job_cycles", 32'(job_cycles), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_job(1'b1, 0, -1, 1'b0, 0, 2, 1'b0);
        run_job(1'b1, 0, 3, 1'b0, 1, 1, 1'b0);
        run_job(1'b0, 0, -1, 1'b1, 0, 0, 1'b0);
        chk_val("error_sticky", 32'(error), 1);
        run_job(1'b0, 20, -1, 1'b0, 3, 2, 1'b1);
        idle_valid_ignored();
        abort_job();
        for (int j = 0; j < 8; j++)
            run_job(1'b0, int'($urandom_range(0, 50)), -1, 1'b0,
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
        run_job(1'b0, 30, -1, 1'b1, 0, 0, 1'b0);
        reset_in_wait();
        run_job(1'b0, 10, -1, 1'b0, 2, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
